// File: rtl/decode_stage.sv
// Decode stage: RV32I ALU/load/store/branch decoder, 32-entry register file with a
// write-first Writeback bypass, and the Decode->Execute pipeline register (hold / bubble).
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     Instr_D,
  input  logic            en_E,
  input  logic            flush_E,
  input  logic            RegWrite_W,
  input  logic [4:0]      Rd_W,
  input  logic [XLEN-1:0] Result_W,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_E,
  output logic [4:0]      Rs1_E,
  output logic [4:0]      Rs2_E,
  output logic [4:0]      Rd_E,
  output logic [2:0]      ALUControl_E,
  output logic            ALUSrc_E,
  output logic            RegWrite_E,
  output logic            MemWrite_E,
  output logic            ResultSrc_E,
  output logic            Branch_E,
  output logic            Illegal_E
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  logic [6:0] w_opcode;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_f3;
  logic       w_f7b5;

  assign w_opcode = Instr_D[6:0];
  assign w_rd     = Instr_D[11:7];
  assign w_f3     = Instr_D[14:12];
  assign w_rs1    = Instr_D[19:15];
  assign w_rs2    = Instr_D[24:20];
  assign w_f7b5   = Instr_D[30];

  // Register file; x0 is never written and is also forced to zero on read.
  logic [XLEN-1:0] r_rf [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (RegWrite_W && (Rd_W != 5'd0)) begin
      r_rf[Rd_W] <= Result_W;
    end
  end

  logic            w_wb_hit;
  logic [XLEN-1:0] w_rd1, w_rd2;

  assign w_wb_hit = RegWrite_W && (Rd_W != 5'd0);

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_rs1 != 5'd0) w_rd1 = (w_wb_hit && (Rd_W == w_rs1)) ? Result_W : r_rf[w_rs1];
    if (w_rs2 != 5'd0) w_rd2 = (w_wb_hit && (Rd_W == w_rs2)) ? Result_W : r_rf[w_rs2];
  end

  // Shared funct3 -> ALU op mapping for R-type and I-ALU.
  logic       w_f3_ok;
  logic [2:0] w_f3_alu;

  always_comb begin
    w_f3_ok  = 1'b1;
    w_f3_alu = AluAdd;
    case (w_f3)
      3'b000:  w_f3_alu = AluAdd;
      3'b111:  w_f3_alu = AluAnd;
      3'b110:  w_f3_alu = AluOr;
      3'b100:  w_f3_alu = AluXor;
      3'b010:  w_f3_alu = AluSlt;
      default: w_f3_ok  = 1'b0;
    endcase
  end

  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_alu_ctl;
  logic            w_alu_src, w_reg_write, w_mem_write, w_result_src, w_branch, w_illegal;

  always_comb begin
    w_imm        = '0;
    w_alu_ctl    = AluAdd;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_result_src = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    case (w_opcode)
      OpR: begin
        if (w_f3_ok) begin
          w_reg_write = 1'b1;
          w_alu_ctl   = ((w_f3 == 3'b000) && w_f7b5) ? AluSub : w_f3_alu;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OpImm: begin
        w_imm = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:20]};
        if (w_f3_ok) begin
          w_reg_write = 1'b1;
          w_alu_src   = 1'b1;
          w_alu_ctl   = w_f3_alu;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OpLoad: begin
        w_imm = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:20]};
        if (w_f3 == 3'b010) begin
          w_reg_write  = 1'b1;
          w_alu_src    = 1'b1;
          w_result_src = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OpStore: begin
        w_imm = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
        if (w_f3 == 3'b010) begin
          w_mem_write = 1'b1;
          w_alu_src   = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OpBranch: begin
        w_imm = {{(XLEN-13){Instr_D[31]}}, Instr_D[31], Instr_D[7], Instr_D[30:25],
                 Instr_D[11:8], 1'b0};
        if (w_f3 == 3'b000) begin
          w_branch  = 1'b1;
          w_alu_ctl = AluSub;
        end else begin
          w_illegal = 1'b1;
        end
      end
      // The all-zero Fetch reset word is a NOP, not an illegal instruction.
      default: w_illegal = (Instr_D != 32'h0);
    endcase
  end

  logic [XLEN-1:0] r_rd1, r_rd2, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [2:0]      r_alu_ctl;
  logic            r_alu_src, r_reg_write, r_mem_write, r_result_src, r_branch, r_illegal;

  always_ff @(posedge clk) begin
    if (rst || flush_E) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_ctl    <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (en_E) begin
      r_rd1        <= w_rd1;
      r_rd2        <= w_rd2;
      r_imm        <= w_imm;
      r_rs1        <= w_rs1;
      r_rs2        <= w_rs2;
      r_rd         <= w_rd;
      r_alu_ctl    <= w_alu_ctl;
      r_alu_src    <= w_alu_src;
      r_reg_write  <= w_reg_write;
      r_mem_write  <= w_mem_write;
      r_result_src <= w_result_src;
      r_branch     <= w_branch;
      r_illegal    <= w_illegal;
    end
  end

  assign RD1_E        = r_rd1;
  assign RD2_E        = r_rd2;
  assign Imm_E        = r_imm;
  assign Rs1_E        = r_rs1;
  assign Rs2_E        = r_rs2;
  assign Rd_E         = r_rd;
  assign ALUControl_E = r_alu_ctl;
  assign ALUSrc_E     = r_alu_src;
  assign RegWrite_E   = r_reg_write;
  assign MemWrite_E   = r_mem_write;
  assign ResultSrc_E  = r_result_src;
  assign Branch_E     = r_branch;
  assign Illegal_E    = r_illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the Fetch→Decode pipeline register.
- Takes the fetched instruction word Instr_D and decodes RV32I ALU, load, store and branch formats.
- Reads a 32x32 register file, with its write port driven from Writeback.
- Registers operands, immediate and control signals into the Decode→Execute pipeline register; supports hold (stall) and bubble insertion (flush).

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register-file depth; register 0 is hardwired to zero.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- Instr_D  input  32  instruction word from the Fetch pipeline register
- en_E  input  1  1 = load the Execute register; 0 = hold its current contents
- flush_E  input  1  1 = load a bubble into the Execute register
- RegWrite_W  input  1  Writeback register-file write enable
- Rd_W  input  5  Writeback destination register
- Result_W  input  32  Writeback data
- RD1_E  output  32  rs1 operand
- RD2_E  output  32  rs2 operand
- Imm_E  output  32  sign-extended immediate
- Rs1_E, Rs2_E, Rd_E  output  5 each  register indices (for a later hazard unit)
- ALUControl_E  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- ALUSrc_E  output  1  1 = second ALU operand is Imm_E
- RegWrite_E  output  1  instruction writes rd
- MemWrite_E  output  1  store
- ResultSrc_E  output  1  1 = load data, 0 = ALU result
- Branch_E  output  1  beq
- Illegal_E  output  1  unsupported encoding seen

Behaviour:
- Reset:
  - All Execute-register outputs are 0.
  - All 32 registers are cleared to 0.
- Latency: one cycle. Outputs reflect the Instr_D present at the previous rising edge.
- Priority at each rising edge is rst > flush_E > en_E.
  - flush_E: loads a bubble, i.e. all outputs 0 (the same as the reset value).
  - en_E=0 with no flush: all outputs hold.
- Register-file write:
  - Occurs when RegWrite_W=1 and Rd_W!=0.
  - Independent of en_E and flush_E.
  - Writes to x0 are discarded; x0 always reads 0.
- Write-first bypass: if RegWrite_W=1, Rd_W!=0 and Rd_W equals rs1 (or rs2) in the same cycle, the captured operand is Result_W, not the stale array value.
- Decode fields: opcode=Instr[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7b5=[30].
- 0110011 R-type:
  - RegWrite=1, ALUSrc=0.
  - f3 000 → add, or sub when f7b5=1; 111 → and; 110 → or; 100 → xor; 010 → slt.
- 0010011 I-ALU: RegWrite=1, ALUSrc=1, f3 mapped as for R-type. f7b5 is ignored, so there is no subi.
- 0000011 with f3=010 (lw): RegWrite=1, ALUSrc=1, ResultSrc=1, ALU add.
- 0100011 with f3=010 (sw): MemWrite=1, ALUSrc=1, ALU add.
- 1100011 with f3=000 (beq): Branch=1, ALU sub.
- Immediate formats:
  - I-type: sext(Instr[31:20]).
  - S-type: sext({Instr[31:25],Instr[11:7]}).
  - B-type: sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],1'b0}).
  - All other formats: 0.
- Instr_D == 32'h00000000 (the Fetch reset value) decodes as a NOP: all control 0 and Illegal_E=0.
- Any other opcode/f3 combination, including shifts and sltu (f3 001/011/101):
  - Illegal_E=1 and all other control outputs 0 (safe bubble).
  - RD1/RD2/Imm/indices are still captured.
- Rs1_E, Rs2_E and Rd_E are always the raw fields, including for bubbles: reset and flush give 0.

Test Plan:
- Reset: assert rst 2 cycles with WB writes active → all outputs 0; a later read of x5 returns 0.
- Basic R-type: WB writes x1=0x12345678 and x2=0x00000010; apply add x3,x1,x2 (0x002081B3) → next cycle RD1_E=0x12345678, RD2_E=0x10, Rd_E=3, ALUControl_E=000, RegWrite_E=1. Then 0x402081B3 → ALUControl_E=001.
- Bypass: in the same cycle as RegWrite_W=1, Rd_W=1, Result_W=0xDEADBEEF, decode 0x002081B3 → RD1_E=0xDEADBEEF. A WB write of 0xFFFF to x0, then reading x0 → 0.
- Immediates:
  - 0xFFF00093 (addi x1,x0,-1) → Imm_E=0xFFFFFFFF, ALUSrc_E=1.
  - 0x0020A423 (sw x2,8(x1)) → Imm_E=8, MemWrite_E=1, RegWrite_E=0.
  - 0xFE000EE3 (beq x0,x0,-4) → Imm_E=0xFFFFFFFC, Branch_E=1.
- Illegal / NOP: 0x002091B3 (sll) → Illegal_E=1, RegWrite_E=0. 0x00000000 → all control 0, Illegal_E=0.
- Hold and flush:
  - Decode 0x00500093, then en_E=0 for 3 cycles with a changing Instr_D → outputs stay Imm_E=5, Rd_E=1.
  - flush_E=1 with en_E=0 → all outputs 0 next cycle.
  - rst together with flush_E → outputs 0 and the register file cleared.
